microcode_sequencer: RTL

//  Sequences the 4-bit Datapath: holds a small loadable program of 8-bit microinstructions and

---
 rtl/microseq_pkg.sv | 7 +
 rtl/microcode_sequencer_if.sv | 30 +++
 rtl/microseq_prog_mem.sv | 18 +
 rtl/microcode_sequencer.sv | 82 ++++++++
 4 files changed

// File: rtl/microseq_pkg.sv
// microseq_pkg: shared state encoding, sequencer opcodes and default NOP for the microcode sequencer
package microseq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b0111;
  localparam logic [7:0] NOP_DEFAULT = 8'h00;
endpackage

// File: rtl/microcode_sequencer_if.sv
// microcode_sequencer_if: host/program-load/datapath-drive bundle; step exists only with SEQ_STEP_EN
interface microcode_sequencer_if #(parameter int AW = 4, parameter int IW = 8);
  logic start;
  logic prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [IW-1:0] instr;
  logic dp_rst;
  logic busy;
  logic done;
  logic abort;
  logic [AW-1:0] pc;
`ifdef SEQ_STEP_EN
  logic step;
`endif
  modport master (
`ifdef SEQ_STEP_EN
    output step,
`endif
    output start, prog_we, prog_addr, prog_data,
    input instr, dp_rst, busy, done, abort, pc
  );
  modport slave (
`ifdef SEQ_STEP_EN
    input step,
`endif
    input start, prog_we, prog_addr, prog_data,
    output instr, dp_rst, busy, done, abort, pc
  );
endinterface

// File: rtl/microseq_prog_mem.sv
// microseq_prog_mem: unreset flop-array program store, synchronous write, asynchronous read
module microseq_prog_mem #(
  parameter int AW = 4,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] mem [2**AW];
  // contents survive grst_n so a program can be rerun after a reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: drives program words onto the datapath with JMP/HALT and a watchdog; SEQ_STEP_EN adds step gating
module microcode_sequencer
  import microseq_pkg::*;
#(
  parameter int            AW         = 4,
  parameter int            IW         = 8,
  parameter logic [IW-1:0] NOP_INSTR  = IW'(NOP_DEFAULT),
  parameter int            MAX_CYCLES = 255
) (
  input logic                  clk,
  input logic                  grst_n,
  microcode_sequencer_if.slave bus
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  state_t state;
  logic [CW-1:0] cyc;
  logic [IW-1:0] w;
  logic [3:0] op;
  logic adv, idle_like;
`ifdef SEQ_STEP_EN
  assign adv = bus.step;
`else
  assign adv = 1'b1;
`endif
  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign op = w[IW-1 -: 4];
  microseq_prog_mem #(.AW(AW), .IW(IW)) u_mem (
    .clk  (clk),
    .we   (bus.prog_we && idle_like),
    .waddr(bus.prog_addr),
    .wdata(bus.prog_data),
    .raddr(bus.pc),
    .rdata(w)
  );
  // sequencer FSM with all outputs registered; HALT beats the watchdog, the watchdog beats JMP
  always_ff @(posedge clk or negedge grst_n)
    if (!grst_n) begin
      state      <= S_IDLE;
      bus.pc     <= '0;
      cyc        <= '0;
      bus.instr  <= NOP_INSTR;
      bus.dp_rst <= 1'b1;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.abort  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE:
          if (bus.start) begin
            state      <= S_CLR;
            bus.pc     <= '0;
            cyc        <= '0;
            bus.instr  <= NOP_INSTR;
            bus.dp_rst <= 1'b1;
            bus.busy   <= 1'b1;
            bus.done   <= 1'b0;
            bus.abort  <= 1'b0;
          end
        S_CLR: begin
          bus.dp_rst <= 1'b0;
          state      <= S_RUN;
        end
        default: begin
          bus.instr <= NOP_INSTR;
          if (adv) begin
            cyc <= cyc + 1'b1;
            if (op == OP_HALT || cyc == CW'(MAX_CYCLES - 1)) begin
              state     <= S_DONE;
              bus.busy  <= 1'b0;
              bus.done  <= 1'b1;
              bus.abort <= op != OP_HALT;
            end else if (op == OP_JMP) begin
              bus.pc <= AW'(w[3:0]);
            end else begin
              bus.instr <= w;
              bus.pc    <= bus.pc + 1'b1;
            end
          end
        end
      endcase
    end
endmodule
